// File: rtl/spi_cfg_if.sv
// Command/response handshake and SPI pin bundle between a requester and spi_cfg_master.
interface spi_cfg_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       spi_rstn;
  logic       spi_sclk;
  logic       spi_dout;
  logic       spi_din;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, spi_din,
    output cmd_ready, rsp_valid, rsp_rdata, busy, spi_rstn, spi_sclk, spi_dout
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, spi_din,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_rstn, spi_sclk, spi_dout
  );
endinterface

// File: rtl/spi_cfg_master.sv
// SPI master for the PSEC5 config slave: one 16-bit frame per command, readback byte
// returned as a one-cycle response; also sequences the slave's active-low reset.
module spi_cfg_master #(
  parameter int CLK_DIV  = 4,
  parameter int RST_HOLD = 4
) (
  input logic        clk,
  input logic        rst,
  spi_cfg_if.master  bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(RST_HOLD + 1);

  localparam logic [1:0] ST_RSTHOLD = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] ph_cnt;
  logic [3:0]    bit_cnt;
  logic [14:0]   sr;
  logic [6:0]    shadow;
  logic          sclk;
  logic          dout;
  logic          rstn;
  logic          ready;
  logic          busy_q;
  logic          rvld;
  logic [7:0]    rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RSTHOLD;
      hold_cnt <= HW'(RST_HOLD);
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      shadow   <= '0;
      sclk     <= 1'b0;
      dout     <= 1'b0;
      rstn     <= 1'b0;
      ready    <= 1'b0;
      busy_q   <= 1'b0;
      rvld     <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      rvld <= 1'b0;
      case (state)
        ST_RSTHOLD: begin
          if (hold_cnt == HW'(1)) begin
            state <= ST_IDLE;
            rstn  <= 1'b1;
            ready <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            // First bit goes straight to the pin; the register keeps the remaining 15.
            state   <= ST_SHIFT;
            dout    <= bus.cmd_addr[7];
            sr      <= {bus.cmd_addr[6:0], bus.cmd_wdata};
            ph_cnt  <= '0;
            bit_cnt <= 4'd15;
            busy_q  <= 1'b1;
            ready   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ph_cnt != PW'(CLK_DIV - 1)) begin
            ph_cnt <= ph_cnt + PW'(1);
          end else begin
            ph_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
              state  <= ST_IDLE;
              sclk   <= 1'b0;
              dout   <= 1'b0;
              busy_q <= 1'b0;
              ready  <= 1'b1;
              rvld   <= 1'b1;
              rdata  <= {shadow, bus.spi_din};
            end else begin
              sclk    <= 1'b0;
              dout    <= sr[14];
              sr      <= {sr[13:0], 1'b0};
              bit_cnt <= bit_cnt - 4'd1;
              // Data phase (bits 8..15) samples at the end of each high phase.
              if (!bit_cnt[3]) shadow <= {shadow[5:0], bus.spi_din};
            end
          end
        end
        default: state <= ST_RSTHOLD;
      endcase
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rvld;
  assign bus.rsp_rdata = rdata;
  assign bus.busy      = busy_q;
  assign bus.spi_rstn  = rstn;
  assign bus.spi_sclk  = sclk;
  assign bus.spi_dout  = dout;
endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master at CLK_DIV=4 and CLK_DIV=2 against a frame-level slave model.
module tb_spi_cfg_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_addr  = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       din       = 1'b1;
  logic       sel       = 1'b0;
  int         D         = 4;

  spi_cfg_if b4();
  spi_cfg_if b2();

  spi_cfg_master #(.CLK_DIV(4), .RST_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  spi_cfg_master #(.CLK_DIV(2), .RST_HOLD(4)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));

  assign b4.cmd_valid = cmd_valid;
  assign b4.cmd_addr  = cmd_addr;
  assign b4.cmd_wdata = cmd_wdata;
  assign b4.spi_din   = din;
  assign b2.cmd_valid = cmd_valid;
  assign b2.cmd_addr  = cmd_addr;
  assign b2.cmd_wdata = cmd_wdata;
  assign b2.spi_din   = din;

  logic       o_ready, o_rvld, o_busy, o_rstn, o_sclk, o_dout;
  logic [7:0] o_rdata;
  assign o_ready = sel ? b2.cmd_ready : b4.cmd_ready;
  assign o_rvld  = sel ? b2.rsp_valid : b4.rsp_valid;
  assign o_busy  = sel ? b2.busy      : b4.busy;
  assign o_rstn  = sel ? b2.spi_rstn  : b4.spi_rstn;
  assign o_sclk  = sel ? b2.spi_sclk  : b4.spi_sclk;
  assign o_dout  = sel ? b2.spi_dout  : b4.spi_dout;
  assign o_rdata = sel ? b2.rsp_rdata : b4.rsp_rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: records spi_dout at each sclk rise, shifts readback out on falls.
  logic       rises[$];
  int         stamps[$];
  int         rise_total = 0;
  int         rsp_cnt = 0;
  logic       prev_sclk = 1'b0;
  logic [7:0] rd_val = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rises.delete();
      stamps.delete();
      rise_total = 0;
      prev_sclk  = 1'b0;
      din        = 1'b1;
    end else begin
      if (o_sclk && !prev_sclk) begin
        rises.push_back(o_dout);
        stamps.push_back(cyc);
        rise_total++;
      end
      if (!o_sclk && prev_sclk) begin
        int n;
        n = rise_total % 16;
        din = (n >= 8) ? rd_val[15 - n] : 1'b1;
      end
      prev_sclk = o_sclk;
      if (o_rvld) rsp_cnt++;
    end
  end

  int ncmp = 0;
  int nfail = 0;
  int acc = 0;
  int base_idx = 0;
  int first_rise = 0;
  int last_rise = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_release();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_rstn_low", {31'd0, o_rstn}, 32'd0);
      chk("rst_ready_low", {31'd0, o_ready}, 32'd0);
      chk("rst_outs_zero", {20'd0, o_sclk, o_dout, o_busy, o_rvld, o_rdata}, 32'd0);
      @(negedge clk);
    end
    chk("rst_rstn_high", {31'd0, o_rstn}, 32'd1);
    chk("rst_ready_high", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] a, input logic [7:0] w);
    int t = 0;
    while (!o_ready && t < 1000) begin @(negedge clk); t++; end
    chk("ready_before_cmd", {31'd0, o_ready}, 32'd1);
    base_idx  = rises.size();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = w;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
    chk("busy_after_accept", {30'd0, o_busy, o_ready}, 32'd2);
  endtask

  task automatic finish_frame(input logic [7:0] a, input logic [7:0] w, input logic [7:0] rd);
    int t = 0;
    int bad = 0;
    logic [15:0] word;
    while (!o_rvld && t < 32 * D + 40) begin @(negedge clk); t++; end
    chk("rsp_valid_seen", {31'd0, o_rvld}, 32'd1);
    chk("latency", cyc - acc, 32 * D + 1);
    chk("rsp_rdata", {24'd0, o_rdata}, {24'd0, rd});
    chk("rise_count", rises.size() - base_idx, 16);
    chk("end_outs", {28'd0, o_sclk, o_dout, o_busy, o_ready}, 32'd1);
    word = 16'h0;
    for (int i = 0; i < 16; i++)
      if (base_idx + i < rises.size()) word[15 - i] = rises[base_idx + i];
    chk("bitstream", {16'd0, word}, {16'd0, a, w});
    if (rises.size() >= base_idx + 16) begin
      first_rise = stamps[base_idx];
      last_rise  = stamps[base_idx + 15];
      chk("first_rise", first_rise - acc, D + 1);
      for (int i = 1; i < 16; i++)
        if (stamps[base_idx + i] - stamps[base_idx + i - 1] != 2 * D) bad++;
      chk("rise_spacing_bad", bad, 0);
    end
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] w, input logic [7:0] rd);
    rd_val = rd;
    start_frame(a, w);
    finish_frame(a, w, rd);
    @(negedge clk);
    chk("rsp_pulse_one_cycle", {31'd0, o_rvld}, 32'd0);
    chk("rsp_rdata_held", {24'd0, o_rdata}, {24'd0, rd});
  endtask

  task automatic back_to_back();
    logic [7:0] a1, w1, r1, a2, w2, r2;
    int last_a;
    a1 = 8'($urandom); w1 = 8'($urandom); r1 = 8'($urandom);
    a2 = 8'($urandom); w2 = 8'($urandom); r2 = 8'($urandom);
    rd_val = r1;
    start_frame(a1, w1);
    cmd_valid = 1'b1;
    cmd_addr  = a2;
    cmd_wdata = w2;
    finish_frame(a1, w1, r1);
    last_a   = last_rise;
    rd_val   = r2;
    base_idx = base_idx + 16;
    acc      = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_accepted", {30'd0, o_busy, o_ready}, 32'd2);
    finish_frame(a2, w2, r2);
    chk("b2b_rise_gap", first_rise - last_a, 2 * D + 1);
  endtask

  task automatic abort_test();
    int t = 0;
    int base_r;
    int cnt0;
    rd_val = 8'($urandom);
    base_r = rise_total;
    start_frame(8'($urandom), 8'($urandom));
    while (rise_total - base_r < 7 && t < 500) begin @(negedge clk); t++; end
    chk("abort_reached_bit6", rise_total - base_r, 7);
    chk("abort_in_high_phase", {31'd0, o_sclk}, 32'd1);
    cnt0 = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs", {26'd0, o_sclk, o_dout, o_rstn, o_busy, o_ready, o_rvld}, 32'd0);
    chk("abort_rdata_cleared", {24'd0, o_rdata}, 32'd0);
    reset_release();
    repeat (200) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - cnt0, 0);
    chk("abort_rdata_still_zero", {24'd0, o_rdata}, 32'd0);
  endtask

  task automatic suite();
    reset_release();
    do_frame(8'h83, 8'hA5, 8'h00);
    do_frame(8'h03, 8'h00, 8'h3C);
    for (int i = 0; i < 3; i++)
      do_frame(8'($urandom), 8'($urandom), 8'($urandom));
    back_to_back();
  endtask

  initial begin
    sel = 1'b0; D = 4;
    suite();
    abort_test();
    do_frame(8'h05, 8'h5A, 8'hC3);
    sel = 1'b1; D = 2;
    suite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

Clock-domain SPI master that drives the PSEC5 configuration SPI slave (registers ch0–ch7). It accepts single-register commands over a valid/ready handshake and serialises each as one 16-bit frame on sclk/serial lines. It captures the slave's serial_out readback and returns it as a one-cycle response. It also sequences the slave's active-low reset so that the slave's bit counter is frame-aligned.

## Interface
- CLK_DIV, 4: sclk half-period in clk cycles; legal ≥2.
- RST_HOLD, 4: clk cycles spi_rstn stays low after rst deasserts; legal ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_addr  in  8  frame byte 0; bit7 = 1 write, 0 read; bits2:0 select ch0–ch7; bits6:3 sent as given.
- cmd_wdata  in  8  frame byte 1; ignored by slave on reads.
- rsp_valid  out  1  one-cycle pulse, frame complete.
- rsp_rdata  out  8  byte captured from spi_din during data phase; held until next rsp_valid.
- busy  out  1  frame in progress.
- spi_rstn  out  1  to slave rstn.
- spi_sclk  out  1  to slave sclk; idle low.
- spi_dout  out  1  to slave serial_in.
- spi_din  in  1  from slave serial_out.

## Operation
- States: RSTHOLD → IDLE → SHIFT → IDLE.
- **RSTHOLD**
  - Entered on rst.
  - spi_rstn=0; cmd_ready=0.
  - A down-counter loaded with RST_HOLD starts when rst deasserts.
  - At zero: spi_rstn=1, go to IDLE.
- **IDLE**
  - cmd_ready=1, busy=0, spi_sclk=0, spi_dout=0.
  - On cmd_valid&&cmd_ready: latch {cmd_addr,cmd_wdata} into a 16-bit shift register; go to SHIFT.
- **SHIFT**
  - 16 bits, MSB first (cmd_addr[7] first, cmd_wdata[0] last).
  - Each bit = low phase (CLK_DIV cycles, spi_dout holds bit) then high phase (CLK_DIV cycles).
  - Slave samples spi_dout on the sclk rising edge.
  - spi_dout changes only at the start of a low phase.
  - For bits 8–15, spi_din is sampled in the last clk cycle of each high phase and shifted MSB-first into rsp_rdata's shadow register.
  - Bits 0–7 readback is ignored.
  - After bit 15's high phase: go to IDLE, pulse rsp_valid, update rsp_rdata.
- cmd_* is sampled only at acceptance; later changes to cmd_* have no effect on the frame.
- Counters:
  - phase counter: $clog2(CLK_DIV) bits, 0..CLK_DIV-1.
  - bit counter: 4 bits, 15..0; no wrap; terminal at 0 after high phase.
- rst mid-frame: abort immediately.
  - Next cycle: spi_sclk=0, spi_dout=0, spi_rstn=0, busy=0, no rsp_valid.
  - rsp_rdata cleared to 0; state RSTHOLD.
- cmd_valid while busy is ignored (cmd_ready=0); requester must hold it.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=8'h00, busy=0, spi_rstn=0, spi_sclk=0, spi_dout=0.
- Cycle 0 = acceptance cycle.
  - Cycles 1..32·CLK_DIV: busy=1, cmd_ready=0.
  - Bit k (k=0..15) low phase: cycles 1+2k·D .. (2k+1)·D.
  - Bit k high phase: (2k+1)·D+1 .. (2k+2)·D.
- Cycle 32·D+1:
  - spi_sclk=0, spi_dout=0, busy=0.
  - rsp_valid=1, rsp_rdata valid.
  - cmd_ready=1; a command accepted in this same cycle starts the next frame with no idle gap.
- Latency, accept → rsp_valid: 32·CLK_DIV+1 cycles (129 at default).
- sclk period: 2·CLK_DIV clk cycles, 50% duty; no glitches; all outputs registered.
- spi_rstn rises RST_HOLD cycles after the first cycle with rst=0; cmd_ready rises in the same cycle.

## Test plan
- **Reset release:**
  - Hold rst 5 cycles, release → spi_rstn=0 and cmd_ready=0 for exactly 4 cycles, then both 1.
  - All other outputs 0 throughout.
- **Write frame:**
  - addr=8'h83, wdata=8'hA5 → spi_dout sampled at each sclk rise = 1000_0011_1010_0101.
  - 16 sclk rises, each 8 clk cycles apart.
  - rsp_valid exactly 129 cycles after accept.
- **Readback:**
  - Slave model drives spi_din = 8'h3C MSB-first on sclk falls during bits 8–15; send addr=8'h03 → rsp_rdata=8'h3C on rsp_valid.
  - Bits 0–7 driven with 8'hFF are ignored.
- **Back-to-back:**
  - cmd_valid held high with two commands → second accepted in the rsp_valid cycle.
  - spi_sclk stays low ≥CLK_DIV cycles between frames; no extra sclk edge.
- **Abort:**
  - Assert rst at bit 6 high phase → next cycle spi_sclk=0, spi_rstn=0, busy=0.
  - No rsp_valid ever for that frame; rsp_rdata=0.
  - Fresh frame after RSTHOLD completes correctly.
- **Parameter corner:**
  - CLK_DIV=2 → sclk period 4 cycles; latency 65; bitstream identical to the default case.
